axis_framer: RTL

- Upstream stage of the stream gearbox.
- Takes an unframed valid/ready word stream and inserts a last flag after a runtime-configured word count, or earlier when the source flags a last word.
- The gearbox therefore sees clean packet boundaries and flushes partial deserialized words at frame ends.
- A two-entry skid buffer registers the output and the upstream ready, so there is no combinational path between the two stream sides.

---
 rtl/axis_framer_pkg.sv | 12 +
 rtl/axis_framer_skid.sv | 66 ++++++
 rtl/axis_framer.sv | 88 ++++++++
 3 files changed

// File: rtl/axis_framer_pkg.sv
// Shared constants for the framer: FSM state encoding and skid buffer sizing.
package axis_framer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/axis_framer_skid.sv
// Two-entry registered valid/ready buffer; the head entry drives the outputs
// directly so nothing downstream sees a combinational path from the push side.
module axis_skid
  import axis_framer_pkg::*;
#(
  parameter int W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          i_data,
  input  logic                  i_push,
  output logic [W-1:0]          o_data,
  output logic                  o_val,
  input  logic                  i_rdy,
  output logic [SKID_CNT_W-1:0] o_cnt_nxt
);

  logic [W-1:0] r_head, r_tail;
  logic         r_head_vld, r_tail_vld;
  logic [W-1:0] w_head_n, w_tail_n;
  logic         w_head_vld_n, w_tail_vld_n;
  logic         w_pop;

  assign w_pop = r_head_vld & i_rdy;

  // Pop first, then the push lands in the first free slot.
  always_comb begin
    w_head_n     = r_head;
    w_tail_n     = r_tail;
    w_head_vld_n = r_head_vld;
    w_tail_vld_n = r_tail_vld;
    if (w_pop) begin
      w_head_vld_n = r_tail_vld;
      w_tail_vld_n = 1'b0;
      if (r_tail_vld) w_head_n = r_tail;
    end
    if (i_push) begin
      if (!w_head_vld_n) begin
        w_head_n     = i_data;
        w_head_vld_n = 1'b1;
      end else begin
        w_tail_n     = i_data;
        w_tail_vld_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_head_vld <= 1'b0;
      r_tail_vld <= 1'b0;
    end else begin
      r_head     <= w_head_n;
      r_tail     <= w_tail_n;
      r_head_vld <= w_head_vld_n;
      r_tail_vld <= w_tail_vld_n;
    end
  end

  assign o_data    = r_head;
  assign o_val     = r_head_vld;
  assign o_cnt_nxt = SKID_CNT_W'(w_head_vld_n) + SKID_CNT_W'(w_tail_vld_n);

endmodule

// File: rtl/axis_framer.sv
// Stream framer: tags a last flag after cfg_len words or on a source-forced
// early end, and emits the tagged stream through a registered skid buffer.
module axis_framer
  import axis_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_val,
  output logic                  cfg_rdy,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  up_last,
  input  logic                  up_val,
  output logic                  up_rdy,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic                  dn_last,
  output logic                  dn_val,
  input  logic                  dn_rdy,
  output logic                  busy
);

  state_t                  r_state;
  logic [LEN_WIDTH-1:0]    r_remaining;
  logic                    r_up_rdy, r_cfg_rdy;
  logic                    w_cfg_xfer, w_up_xfer, w_tag, w_has_room;
  logic [SKID_CNT_W-1:0]   w_cnt_nxt;
  logic [DATA_WIDTH:0]     w_out;

  assign w_cfg_xfer = cfg_val & r_cfg_rdy;
  assign w_up_xfer  = up_val & r_up_rdy;
  assign w_tag      = (r_remaining == LEN_WIDTH'(1)) | up_last;
  assign w_has_room = (w_cnt_nxt != SKID_CNT_W'(SKID_DEPTH));

  // up_rdy is looked ahead from the buffer's next fill so it can be a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_up_rdy    <= 1'b0;
      r_cfg_rdy   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_up_rdy <= 1'b0;
          if (w_cfg_xfer && cfg_len != '0) begin
            r_state     <= ST_RUN;
            r_remaining <= cfg_len;
            r_cfg_rdy   <= 1'b0;
            r_up_rdy    <= w_has_room;
          end
        end
        ST_RUN: begin
          r_up_rdy <= w_has_room;
          if (w_up_xfer) begin
            if (r_remaining != '0) r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (w_tag) begin
              r_state   <= ST_IDLE;
              r_cfg_rdy <= 1'b1;
              r_up_rdy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  axis_skid #(.W(DATA_WIDTH + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_data    ({up_data, w_tag}),
    .i_push    (w_up_xfer),
    .o_data    (w_out),
    .o_val     (dn_val),
    .i_rdy     (dn_rdy),
    .o_cnt_nxt (w_cnt_nxt)
  );

  assign dn_data = w_out[DATA_WIDTH:1];
  assign dn_last = w_out[0];
  assign up_rdy  = r_up_rdy;
  assign cfg_rdy = r_cfg_rdy;
  assign busy    = (r_state == ST_RUN) | dn_val;

endmodule
